uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit device among NumSrc byte-stream
// requesters. Grants are round-robin and held for a whole message (until the
// owner's last byte or an idle-gap timeout). Each byte is sent as a status
// poll followed by a TX register write once the TX FIFO reports not-full.
module uart_tx_arbiter #(
    parameter int unsigned NumSrc       = 4,
    parameter logic [31:0] UartBase     = 32'h0,
    parameter logic [31:0] TxOffset     = 32'h0,
    parameter logic [31:0] StatusOffset = 32'h4,
    parameter int unsigned MaxGap       = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumSrc-1:0]     src_valid_i,
    input  logic [8*NumSrc-1:0]   src_data_i,
    input  logic [NumSrc-1:0]     src_last_i,
    output logic [NumSrc-1:0]     src_ready_o,
    output logic [NumSrc-1:0]     grant_o,
    output logic                  busy_o,
    output logic                  dev_req_o,
    output logic [31:0]           dev_addr_o,
    output logic                  dev_we_o,
    output logic [3:0]            dev_be_o,
    output logic [31:0]           dev_wdata_o,
    input  logic                  dev_rvalid_i,
    input  logic [31:0]           dev_rdata_i
);

    localparam int unsigned IdxW       = (NumSrc > 1) ? $clog2(NumSrc) : 1;
    localparam int unsigned GapW       = $clog2(MaxGap + 1);
    localparam logic [31:0] StatusAddr = UartBase + StatusOffset;
    localparam logic [31:0] TxAddr     = UartBase + TxOffset;
    localparam logic [GapW-1:0] GapLast = GapW'(MaxGap - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POLL  = 3'd1,
        PWAIT = 3'd2,
        WRITE = 3'd3,
        WWAIT = 3'd4,
        HOLD  = 3'd5
    } state_e;

    state_e          state_q;
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] owner_q;
    logic            last_q;
    logic [GapW-1:0] gap_q;

    logic [IdxW-1:0] pick_idx;
    logic            pick_vld;
    logic            owner_vld;
    logic            owner_last;
    logic [7:0]      owner_byte;
    logic            pop;
    logic            unused_rdata;

    // Successor of a source index, wrapping at NumSrc.
    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        if (int'(idx) == int'(NumSrc) - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // One-hot vector for a source index.
    function automatic logic [NumSrc-1:0] to_onehot(input logic [IdxW-1:0] idx);
        logic [NumSrc-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign owner_vld    = src_valid_i[owner_q];
    assign owner_last   = src_last_i[owner_q];
    assign owner_byte   = src_data_i[{owner_q, 3'b000} +: 8];
    assign unused_rdata = ^dev_rdata_i[31:1];

    // The byte is popped in the same cycle the not-full status returns, so the
    // ready pulse cannot be registered; it only ever targets the owner.
    assign pop         = (state_q == PWAIT) && dev_rvalid_i && !dev_rdata_i[0] && owner_vld;
    assign src_ready_o = pop ? grant_o : '0;

    // Round-robin pick: first valid source at or after the pointer, with wrap.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
            if (src_valid_i[IdxW'((int'(ptr_q) + i) % int'(NumSrc))]) begin
                pick_vld = 1'b1;
                pick_idx = IdxW'((int'(ptr_q) + i) % int'(NumSrc));
            end
        end
    end

    // Message FSM with registered grant and device-port outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            last_q      <= 1'b0;
            gap_q       <= '0;
            grant_o     <= '0;
            busy_o      <= 1'b0;
            dev_req_o   <= 1'b0;
            dev_addr_o  <= '0;
            dev_we_o    <= 1'b0;
            dev_be_o    <= '0;
            dev_wdata_o <= '0;
        end else begin
            dev_req_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        owner_q    <= pick_idx;
                        grant_o    <= to_onehot(pick_idx);
                        busy_o     <= 1'b1;
                        dev_req_o  <= 1'b1;
                        dev_addr_o <= StatusAddr;
                        dev_we_o   <= 1'b0;
                        dev_be_o   <= 4'b0001;
                        state_q    <= POLL;
                    end
                end
                POLL: begin
                    state_q <= PWAIT;
                end
                PWAIT: begin
                    if (dev_rvalid_i) begin
                        if (dev_rdata_i[0]) begin
                            // FIFO full: re-poll immediately.
                            dev_req_o  <= 1'b1;
                            dev_addr_o <= StatusAddr;
                            dev_we_o   <= 1'b0;
                            dev_be_o   <= 4'b0001;
                            state_q    <= POLL;
                        end else if (owner_vld) begin
                            // dev_wdata_o doubles as the captured byte register.
                            last_q      <= owner_last;
                            dev_req_o   <= 1'b1;
                            dev_addr_o  <= TxAddr;
                            dev_we_o    <= 1'b1;
                            dev_be_o    <= 4'b0001;
                            dev_wdata_o <= {24'h0, owner_byte};
                            state_q     <= WRITE;
                        end else begin
                            gap_q   <= '0;
                            state_q <= HOLD;
                        end
                    end
                end
                WRITE: begin
                    state_q <= WWAIT;
                end
                WWAIT: begin
                    if (dev_rvalid_i) begin
                        if (last_q) begin
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            ptr_q   <= next_idx(owner_q);
                            state_q <= IDLE;
                        end else if (owner_vld) begin
                            dev_req_o  <= 1'b1;
                            dev_addr_o <= StatusAddr;
                            dev_we_o   <= 1'b0;
                            dev_be_o   <= 4'b0001;
                            state_q    <= POLL;
                        end else begin
                            gap_q   <= '0;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (owner_vld) begin
                        // Status seen before the gap may be stale, so poll again.
                        gap_q      <= '0;
                        dev_req_o  <= 1'b1;
                        dev_addr_o <= StatusAddr;
                        dev_we_o   <= 1'b0;
                        dev_be_o   <= 4'b0001;
                        state_q    <= POLL;
                    end else if (gap_q == GapLast) begin
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        ptr_q   <= next_idx(owner_q);
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: queue-based sources, a simple
// one-outstanding UART device with configurable latency, per-scenario tasks.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [N-1:0]  src_valid_i;
    logic [8*N-1:0] src_data_i;
    logic [N-1:0]  src_last_i;
    logic [N-1:0]  src_ready_o;
    logic [N-1:0]  grant_o;
    logic          busy_o;
    logic          dev_req_o;
    logic [31:0]   dev_addr_o;
    logic          dev_we_o;
    logic [3:0]    dev_be_o;
    logic [31:0]   dev_wdata_o;
    logic          dev_rvalid_i;
    logic [31:0]   dev_rdata_i;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NumSrc(N), .UartBase(32'h0), .TxOffset(32'h0), .StatusOffset(32'h4), .MaxGap(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_last_i(src_last_i),
        .src_ready_o(src_ready_o), .grant_o(grant_o), .busy_o(busy_o),
        .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
        .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
        .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc;

    // Source queues: bit 8 = last, bits 7:0 = byte.
    logic [8:0] sq [N][16];
    int         sh [N];
    int         st [N];
    logic [N-1:0] en;

    // Device model state.
    int          lat, pend, dly;
    logic [31:0] resp, p_addr;
    logic        p_we;
    logic [31:0] stat_q [16];
    int          stat_h, stat_t;

    // Logs.
    int          stat_cnt, wr_cnt, ngr, viol, rel_cyc, stat_at_wr1, pop_stat;
    logic [7:0]  wr_data [32];
    int          wr_cyc [32];
    int          poll_cyc [32];
    int          grants [16];
    int          pops [N];
    logic        busy_at_rel;
    logic [N-1:0] prev_grant;

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            sh[k] = 0; st[k] = 0; pops[k] = 0;
            for (int j = 0; j < 16; j++) sq[k][j] = '0;
        end
        en = '1; lat = 1; pend = 0; dly = 0; resp = '0; p_addr = '0; p_we = 1'b0;
        stat_h = 0; stat_t = 0; stat_cnt = 0; wr_cnt = 0; ngr = 0; viol = 0;
        rel_cyc = -1; stat_at_wr1 = -1; pop_stat = -1; busy_at_rel = 1'b1;
    endtask

    task automatic push(input int k, input logic [8:0] v);
        sq[k][st[k]] = v;
        st[k]++;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            src_valid_i[k]         = en[k] && (sh[k] != st[k]);
            src_data_i[8*k +: 8]   = src_valid_i[k] ? sq[k][sh[k]][7:0] : 8'h00;
            src_last_i[k]          = src_valid_i[k] ? sq[k][sh[k]][8] : 1'b0;
        end
    endtask

    // One clock: sample ready before the edge, then model the device and
    // drive the next input values after the edge.
    task automatic tick();
        logic [N-1:0] r;
        #1;
        r = src_ready_o;
        for (int k = 0; k < N; k++) begin
            if (r[k]) begin
                if (!grant_o[k]) viol++;
                pops[k]++;
                if (pop_stat < 0) pop_stat = stat_cnt;
                if (sh[k] != st[k]) sh[k]++;
                else viol++;
            end
        end
        @(posedge clk); #1;
        cyc++;
        if (grant_o != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++) if (grant_o[k] && ngr < 16) grants[ngr] = k;
            ngr++;
        end
        if (grant_o == '0 && prev_grant != '0) begin
            rel_cyc = cyc;
            busy_at_rel = busy_o;
        end
        if ($countones(grant_o) > 1) viol++;
        if (busy_o != (grant_o != '0)) viol++;
        prev_grant = grant_o;
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = '0;
        if (pend != 0) begin
            if (dev_req_o || dev_addr_o !== p_addr || dev_we_o !== p_we) viol++;
            dly--;
            if (dly == 0) begin
                dev_rvalid_i = 1'b1;
                dev_rdata_i  = resp;
                pend = 0;
            end
        end else if (dev_req_o) begin
            if (dev_be_o !== 4'b0001) viol++;
            pend = 1; dly = lat; p_addr = dev_addr_o; p_we = dev_we_o;
            if (!dev_we_o) begin
                if (dev_addr_o !== 32'h4) viol++;
                if (stat_cnt < 32) poll_cyc[stat_cnt] = cyc;
                stat_cnt++;
                if (stat_h != stat_t) begin resp = stat_q[stat_h]; stat_h++; end
                else resp = 32'h0;
            end else begin
                if (dev_addr_o !== 32'h0 || dev_wdata_o[31:8] !== 24'h0) viol++;
                if (wr_cnt == 0) stat_at_wr1 = stat_cnt;
                if (wr_cnt < 32) begin wr_data[wr_cnt] = dev_wdata_o[7:0]; wr_cyc[wr_cnt] = cyc; end
                wr_cnt++;
                resp = 32'h0;
            end
        end
        drive_inputs();
    endtask

    task automatic run_idle(input int maxc, output bit to);
        bit empty;
        to = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            tick();
            empty = 1'b1;
            for (int k = 0; k < N; k++) if (sh[k] != st[k]) empty = 1'b0;
            if (empty && !busy_o && pend == 0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_model();
        drive_inputs();
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = '0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_i = 1'b0;
        @(posedge clk); #1;
        cyc = 0;
        prev_grant = grant_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        src_valid_i = '1; src_data_i = '1; src_last_i = '0;
        dev_rvalid_i = 1'b1; dev_rdata_i = '0;
        @(posedge clk); #1;
        tests_run++;
        if ({grant_o, busy_o} !== '0) begin tests_failed++;
            $display("FAIL reset_grant: grant=%b busy=%b, required 0", grant_o, busy_o); end
        tests_run++;
        if ({dev_req_o, dev_we_o, dev_be_o} !== '0) begin tests_failed++;
            $display("FAIL reset_ctrl: req=%b we=%b be=%b, required 0", dev_req_o, dev_we_o, dev_be_o); end
        tests_run++;
        if ({dev_addr_o, dev_wdata_o} !== '0) begin tests_failed++;
            $display("FAIL reset_data: addr=%h wdata=%h, required 0", dev_addr_o, dev_wdata_o); end
        tests_run++;
        if (src_ready_o !== '0) begin tests_failed++;
            $display("FAIL reset_ready: ready=%b, required 0", src_ready_o); end
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (stat_cnt != 0 || busy_o !== 1'b0) begin tests_failed++;
            $display("FAIL idle_quiet: reqs=%0d busy=%b, required 0 and 0", stat_cnt, busy_o); end
    endtask

    task automatic test_single_message();
        bit to;
        do_reset();
        push(0, 9'h041); push(0, 9'h142);
        drive_inputs();
        run_idle(60, to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL single_timeout: did not go idle"); end
        tests_run++;
        if (stat_cnt != 2 || wr_cnt != 2) begin tests_failed++;
            $display("FAIL single_counts: reads=%0d writes=%0d, required 2 and 2", stat_cnt, wr_cnt); end
        tests_run++;
        if (wr_data[0] !== 8'h41 || wr_data[1] !== 8'h42) begin tests_failed++;
            $display("FAIL single_wdata: %h %h, required 41 42", wr_data[0], wr_data[1]); end
        tests_run++;
        if (pops[0] != 2) begin tests_failed++;
            $display("FAIL single_pops: %0d, required 2", pops[0]); end
        tests_run++;
        if (poll_cyc[0] != 1) begin tests_failed++;
            $display("FAIL single_first_req: cycle %0d, required 1", poll_cyc[0]); end
        tests_run++;
        if (wr_cyc[1] - wr_cyc[0] != 4 || poll_cyc[1] - poll_cyc[0] != 4) begin tests_failed++;
            $display("FAIL single_rate: wr gap %0d poll gap %0d, required 4", wr_cyc[1] - wr_cyc[0], poll_cyc[1] - poll_cyc[0]); end
        tests_run++;
        if (rel_cyc != wr_cyc[1] + 2) begin tests_failed++;
            $display("FAIL single_release: cycle %0d, required %0d", rel_cyc, wr_cyc[1] + 2); end
        tests_run++;
        if (viol != 0) begin tests_failed++;
            $display("FAIL single_protocol: %0d violations, required 0", viol); end
    endtask

    task automatic test_round_robin();
        bit to;
        do_reset();
        push(0, 9'h1A0); push(0, 9'h1A4); push(1, 9'h1B1); push(3, 9'h1D3);
        drive_inputs();
        run_idle(120, to);
        tests_run++;
        if (to || ngr != 4) begin tests_failed++;
            $display("FAIL rr_grants: timeout=%0d grants=%0d, required 0 and 4", to, ngr); end
        tests_run++;
        if (grants[0] != 0 || grants[1] != 1 || grants[2] != 3 || grants[3] != 0) begin tests_failed++;
            $display("FAIL rr_order: %0d %0d %0d %0d, required 0 1 3 0", grants[0], grants[1], grants[2], grants[3]); end
        tests_run++;
        if (wr_data[0] !== 8'hA0 || wr_data[1] !== 8'hB1 || wr_data[2] !== 8'hD3 || wr_data[3] !== 8'hA4) begin tests_failed++;
            $display("FAIL rr_wdata: %h %h %h %h, required A0 B1 D3 A4", wr_data[0], wr_data[1], wr_data[2], wr_data[3]); end
        tests_run++;
        if (viol != 0) begin tests_failed++;
            $display("FAIL rr_protocol: %0d violations, required 0", viol); end
    endtask

    task automatic test_fifo_full();
        bit to;
        do_reset();
        lat = 2;
        stat_q[0] = 32'h1; stat_q[1] = 32'h1; stat_q[2] = 32'h1; stat_q[3] = 32'h0; stat_t = 4;
        push(0, 9'h155);
        drive_inputs();
        run_idle(80, to);
        tests_run++;
        if (to || stat_cnt != 4 || wr_cnt != 1) begin tests_failed++;
            $display("FAIL full_counts: timeout=%0d reads=%0d writes=%0d, required 0 4 1", to, stat_cnt, wr_cnt); end
        tests_run++;
        if (stat_at_wr1 != 4 || pop_stat != 4) begin tests_failed++;
            $display("FAIL full_order: reads before write=%0d before pop=%0d, required 4 and 4", stat_at_wr1, pop_stat); end
        tests_run++;
        if (wr_data[0] !== 8'h55 || pops[0] != 1) begin tests_failed++;
            $display("FAIL full_data: wdata=%h pops=%0d, required 55 and 1", wr_data[0], pops[0]); end
        tests_run++;
        if (viol != 0) begin tests_failed++;
            $display("FAIL full_protocol: %0d violations, required 0", viol); end
    endtask

    task automatic test_atomicity();
        bit done;
        do_reset();
        push(2, 9'h021); push(2, 9'h022); push(2, 9'h123); push(0, 9'h101);
        en = 4'b1110;
        drive_inputs();
        done = 1'b0;
        for (int i = 0; i < 150 && !done; i++) begin
            tick();
            if (grant_o == 4'b0100 && en[0] == 1'b0) begin en = '1; drive_inputs(); end
            if (sh[0] == st[0] && sh[2] == st[2] && !busy_o && pend == 0) done = 1'b1;
        end
        tests_run++;
        if (!done || wr_cnt != 4) begin tests_failed++;
            $display("FAIL atom_counts: done=%0d writes=%0d, required 1 and 4", done, wr_cnt); end
        tests_run++;
        if (wr_data[0] !== 8'h21 || wr_data[1] !== 8'h22 || wr_data[2] !== 8'h23 || wr_data[3] !== 8'h01) begin tests_failed++;
            $display("FAIL atom_order: %h %h %h %h, required 21 22 23 01", wr_data[0], wr_data[1], wr_data[2], wr_data[3]); end
        tests_run++;
        if (ngr != 2 || grants[0] != 2 || grants[1] != 0) begin tests_failed++;
            $display("FAIL atom_grants: n=%0d first=%0d second=%0d, required 2 2 0", ngr, grants[0], grants[1]); end
        tests_run++;
        if (viol != 0) begin tests_failed++;
            $display("FAIL atom_protocol: %0d violations, required 0", viol); end
    endtask

    task automatic test_gap_timeout();
        bit to;
        do_reset();
        push(1, 9'h077);
        drive_inputs();
        for (int i = 0; i < 60 && rel_cyc < 0; i++) tick();
        tests_run++;
        if (wr_cnt != 1 || wr_data[0] !== 8'h77 || pops[1] != 1) begin tests_failed++;
            $display("FAIL gap_byte: writes=%0d wdata=%h pops=%0d, required 1 77 1", wr_cnt, wr_data[0], pops[1]); end
        tests_run++;
        if (rel_cyc != wr_cyc[0] + 10) begin tests_failed++;
            $display("FAIL gap_release: cycle %0d, required %0d", rel_cyc, wr_cyc[0] + 10); end
        tests_run++;
        if (busy_at_rel !== 1'b0) begin tests_failed++;
            $display("FAIL gap_busy: busy=%b at release, required 0", busy_at_rel); end
        push(0, 9'h130); push(1, 9'h131); push(2, 9'h132);
        drive_inputs();
        run_idle(100, to);
        tests_run++;
        if (to || ngr != 4 || grants[1] != 2 || grants[2] != 0 || grants[3] != 1) begin tests_failed++;
            $display("FAIL gap_pointer: n=%0d order %0d %0d %0d, required 4 then 2 0 1", ngr, grants[1], grants[2], grants[3]); end
        tests_run++;
        if (viol != 0) begin tests_failed++;
            $display("FAIL gap_protocol: %0d violations, required 0", viol); end
    endtask

    task automatic test_reset_midop();
        int bad;
        do_reset();
        lat = 3;
        push(0, 9'h099); push(0, 9'h19A);
        drive_inputs();
        for (int i = 0; i < 30 && wr_cnt == 0; i++) tick();
        tick();
        tests_run++;
        if (wr_cnt != 1 || pend == 0) begin tests_failed++;
            $display("FAIL midop_setup: writes=%0d pending=%0d, required 1 and 1", wr_cnt, pend); end
        #2;
        rst_i = 1'b1;
        #1;
        tests_run++;
        if ({grant_o, busy_o, dev_req_o, dev_we_o, dev_be_o, src_ready_o} !== '0 || {dev_addr_o, dev_wdata_o} !== '0) begin tests_failed++;
            $display("FAIL midop_outputs: grant=%b busy=%b req=%b addr=%h wdata=%h, required 0", grant_o, busy_o, dev_req_o, dev_addr_o, dev_wdata_o); end
        for (int k = 0; k < N; k++) sh[k] = st[k];
        pend = 0;
        drive_inputs();
        #2;
        rst_i = 1'b0;
        @(posedge clk); #1;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h0;
        #1;
        bad = 0;
        if (src_ready_o !== '0) bad++;
        @(posedge clk); #1;
        dev_rvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dev_req_o !== 1'b0 || grant_o !== '0) bad++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++;
            $display("FAIL midop_late_rvalid: %0d bad cycles, required 0", bad); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        src_valid_i = '0; src_data_i = '0; src_last_i = '0;
        dev_rvalid_i = 1'b0; dev_rdata_i = '0;
        cyc = 0; prev_grant = '0;
        clear_model();
        test_reset();
        test_single_message();
        test_round_robin();
        test_fifo_full();
        test_atomicity();
        test_gap_timeout();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
